uart_tx_fifo: RTL

- Buffered UART transmitter: a host pushes bytes into a small FIFO, and the block serialises them on txd as 8N1 frames, or 8E1/8O1 when parity is enabled.
- It is the transmit-side counterpart to the existing receive path and sits between the host logic and the serial pin.
- The bit period is a fixed number of sys_clk cycles, matching the 8-clocks-per-bit timing used in the UART benches.

---
 rtl/uart_tx_fifo.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: small byte FIFO feeding an 8N1 / 8E1 / 8O1 serialiser.
// The FSM pops straight from IDLE or from the last stop-bit cycle, so queued frames run back to back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 8,
  parameter int ADDR_W       = 2,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              txd,
  output logic              busy,
  output logic              tx_done
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_DONE = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              state;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count_next;
  logic                push;
  logic                pop;
  logic [7:0]          head;
  logic [7:0]          shreg;
  logic                par;
  logic [2:0]          bit_idx;
  logic [BAUD_W-1:0]   baud;

  assign head = mem[rd_ptr];

  // full is the registered value, so a push while full is refused even on a pop edge
  always_comb begin
    push       = wr_en && !full;
    pop        = !empty && ((state == S_IDLE) || (state == S_STOP && baud == BAUD_LAST));
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= S_IDLE;
      txd     <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      shreg   <= '0;
      par     <= 1'b0;
      bit_idx <= '0;
      baud    <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          txd  <= 1'b1;
          baud <= '0;
          if (!empty) begin
            shreg <= head;
            par   <= (^head) ^ PAR_ODD;
            txd   <= 1'b0;
            busy  <= 1'b1;
            state <= S_START;
          end
        end
        S_START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            txd     <= shreg[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                txd   <= par;
                state <= S_PARITY;
              end else begin
                txd   <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            txd   <= 1'b1;
            state <= S_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_STOP: begin
          // raised one edge early so the registered pulse covers the final stop cycle
          if (baud == BAUD_DONE)
            tx_done <= 1'b1;
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (!empty) begin
              shreg <= head;
              par   <= (^head) ^ PAR_ODD;
              txd   <= 1'b0;
              state <= S_START;
            end else begin
              txd   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          baud  <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
